// File: rtl/rgb_pixel_packer.sv
// Packs RGB565 pixel pairs into 32-bit words and buffers them, tagged SOP/EOP, toward an Avalon-ST sink.
// Latency: a word pushed into an empty FIFO is presented with ovalid one cycle later; output held while !iready.
// Backpressure: when the FIFO is full a word is dropped, ooverflow sticks, and the frame is abandoned until the next boundary.
// Optional macro PACKER_TEST_PATTERN_EN adds port itest (pixel data replaced by the pixel counter).

module packer_fifo #(
    parameter int W  = 34,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          push_rdy,
    output logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    input  logic          pop_rdy,
    output logic [AW:0]   fill
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign pop_vld  = (count != '0);
    // A pop in the same cycle frees the slot, so push at full still succeeds.
    assign push_rdy = (count != FULL) || pop_rdy;
    assign do_pop   = pop_vld && pop_rdy;
    assign do_push  = push_vld && push_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
    assign fill     = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module rgb_pixel_packer #(
    parameter int LINE_WIDTH = 640,
    parameter int LINES      = 480,
    parameter int FIFO_AW    = 4
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                idval,
    input  logic [11:0]         ired,
    input  logic [11:0]         igreen,
    input  logic [11:0]         iblue,
    input  logic [31:0]         iframe,
`ifdef PACKER_TEST_PATTERN_EN
    input  logic                itest,
`endif
    output logic [31:0]         odata,
    output logic                ovalid,
    input  logic                iready,
    output logic                osop,
    output logic                oeop,
    output logic                ooverflow,
    output logic [FIFO_AW:0]    ofill
);
    localparam int NPIX = LINE_WIDTH * LINES;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, idx;
    logic [15:0]   half, half_n, pix;
    logic          half_vld, half_vld_n;
    logic          ovf, ovf_n;
    logic [31:0]   frame_q;
    logic          bnd;
    logic          take;
    logic          push_vld;
    logic          push_rdy;
    logic [33:0]   push_dat;
    logic [33:0]   pop_dat;

    assign bnd  = (iframe != frame_q);
    // A pixel arriving with the boundary is pixel 0 of the new frame.
    assign idx  = bnd ? '0 : cnt;
    assign take = idval && (bnd || state == ACTIVE);

`ifdef PACKER_TEST_PATTERN_EN
    assign pix = itest ? 16'(idx) : {ired[11:7], igreen[11:6], iblue[11:7]};
`else
    assign pix = {ired[11:7], igreen[11:6], iblue[11:7]};
`endif

    assign push_vld = take && idx[0] && half_vld;
    assign push_dat = {(idx == CW'(1)), (idx == LAST), pix, half};

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        half_n     = half;
        half_vld_n = half_vld;
        ovf_n      = ovf;
        if (bnd) begin
            state_n    = ACTIVE;
            cnt_n      = '0;
            half_vld_n = 1'b0;
        end
        if (take) begin
            cnt_n = idx + CW'(1);
            if (!idx[0]) begin
                half_n     = pix;
                half_vld_n = 1'b1;
            end
        end
        if (push_vld) begin
            half_vld_n = 1'b0;
            if (!push_rdy) begin
                ovf_n   = 1'b1;
                state_n = DROP;
            end else if (idx == LAST) begin
                state_n = WAIT_SOF;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state    <= WAIT_SOF;
            cnt      <= '0;
            half     <= '0;
            half_vld <= 1'b0;
            ovf      <= 1'b0;
            frame_q  <= iframe;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            half     <= half_n;
            half_vld <= half_vld_n;
            ovf      <= ovf_n;
            frame_q  <= iframe;
        end
    end

    packer_fifo #(.W(34), .AW(FIFO_AW)) u_fifo (
        .clk      (iclk),
        .rst      (irst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (ovalid),
        .pop_dat  (pop_dat),
        .pop_rdy  (iready),
        .fill     (ofill)
    );

    assign odata     = pop_dat[31:0];
    assign oeop      = pop_dat[32];
    assign osop      = pop_dat[33];
    assign ooverflow = ovf;
endmodule

// File: tb/tb_rgb_pixel_packer.sv
// Randomized and directed bench for rgb_pixel_packer against a queue-based frame/word model.
module tb_rgb_pixel_packer;
    localparam int LW    = 4;
    localparam int LN    = 2;
    localparam int AW    = 2;
    localparam int NPIX  = LW * LN;
    localparam int DEPTH = 2 ** AW;

    logic        iclk = 1'b0;
    logic        irst;
    logic        idval;
    logic [11:0] ired, igreen, iblue;
    logic [31:0] iframe;
    logic        iready;
    logic [31:0] odata;
    logic        ovalid, osop, oeop, ooverflow;
    logic [AW:0] ofill;
`ifdef PACKER_TEST_PATTERN_EN
    logic        itest;
`endif

    always #5 iclk = ~iclk;

    rgb_pixel_packer #(.LINE_WIDTH(LW), .LINES(LN), .FIFO_AW(AW)) dut (
        .iclk      (iclk),
        .irst      (irst),
        .idval     (idval),
        .ired      (ired),
        .igreen    (igreen),
        .iblue     (iblue),
        .iframe    (iframe),
`ifdef PACKER_TEST_PATTERN_EN
        .itest     (itest),
`endif
        .odata     (odata),
        .ovalid    (ovalid),
        .iready    (iready),
        .osop      (osop),
        .oeop      (oeop),
        .ooverflow (ooverflow),
        .ofill     (ofill)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: expected FIFO contents as {sop, eop, data}, frame mode 0=wait 1=active 2=drop.
    logic [33:0] mq[$];
    logic [33:0] log_q[$];
    int          mode;
    int          mcnt;
    logic [15:0] mhalf;
    logic [31:0] mprev;
    bit          movf;

    logic [31:0] fr_g;
    bit          rdy_g;
    bit          tst_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rgb565(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        return {r[11:7], g[11:6], b[11:7]};
    endfunction

    task automatic compare_outputs();
        chk("ovalid", {63'd0, ovalid}, {63'd0, mq.size() != 0});
        chk("ofill", 64'(ofill), 64'(mq.size()));
        chk("ooverflow", {63'd0, ooverflow}, {63'd0, movf});
        if (mq.size() != 0)
            chk("word", {30'd0, osop, oeop, odata}, {30'd0, mq[0]});
    endtask

    task automatic model_reset();
        mq.delete();
        mode  = 0;
        mcnt  = 0;
        mhalf = '0;
        movf  = 1'b0;
        mprev = fr_g;
    endtask

    task automatic tick(input bit dv, input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        bit          pop, full;
        logic [15:0] p;
        logic [33:0] w;
        @(negedge iclk);
        compare_outputs();
        if (ovalid && rdy_g) log_q.push_back({osop, oeop, odata});
        irst = 1'b0; idval = dv; ired = r; igreen = g; iblue = b;
        iframe = fr_g; iready = rdy_g;
`ifdef PACKER_TEST_PATTERN_EN
        itest = tst_g;
`endif
        pop  = (mq.size() != 0) && rdy_g;
        full = (mq.size() >= DEPTH);
        if (fr_g != mprev) begin
            mode = 1;
            mcnt = 0;
        end
        mprev = fr_g;
        if (pop) void'(mq.pop_front());
        if (dv && mode == 1) begin
            p = tst_g ? 16'(mcnt) : rgb565(r, g, b);
            if (mcnt % 2 == 0) begin
                mhalf = p;
            end else begin
                w = {(mcnt == 1), (mcnt == NPIX - 1), p, mhalf};
                if (full && !pop) begin
                    movf = 1'b1;
                    mode = 2;
                end else begin
                    mq.push_back(w);
                    if (mcnt == NPIX - 1) mode = 0;
                end
            end
            mcnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge iclk);
        compare_outputs();
        irst = 1'b1; idval = 1'b0; iframe = fr_g; iready = rdy_g;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 12'h0, 12'h0, 12'h0);
    endtask

    task automatic settle();
        @(posedge iclk);
        #1;
    endtask

    logic [11:0] pr[NPIX], pg[NPIX], pb[NPIX];

    initial begin
        irst = 1'b1; idval = 1'b0; ired = '0; igreen = '0; iblue = '0;
        iframe = '0; iready = 1'b0;
`ifdef PACKER_TEST_PATTERN_EN
        itest = 1'b0;
`endif
        fr_g = '0; rdy_g = 1'b1; tst_g = 1'b0;
        repeat (3) @(posedge iclk);
        model_reset();
        #1;
        chk("rst_ovalid", {63'd0, ovalid}, 64'd0);
        chk("rst_odata", {32'd0, odata}, 64'd0);
        chk("rst_sop_eop", {62'd0, osop, oeop}, 64'd0);
        chk("rst_ovf", {63'd0, ooverflow}, 64'd0);
        chk("rst_fill", 64'(ofill), 64'd0);

        // Full-white frame.
        fr_g = 1; idle(1);
        log_q.delete();
        for (int i = 0; i < NPIX; i++) tick(1'b1, 12'hFFF, 12'hFFF, 12'hFFF);
        idle(6);
        chk("white_cnt", 64'(log_q.size()), 64'd4);
        chk("white_w0", {30'd0, log_q[0]}, {30'd0, 2'b10, 32'hFFFF_FFFF});
        chk("white_w1", {30'd0, log_q[1]}, {30'd0, 2'b00, 32'hFFFF_FFFF});
        chk("white_w3", {30'd0, log_q[3]}, {30'd0, 2'b01, 32'hFFFF_FFFF});
        chk("white_ovf", {63'd0, ooverflow}, 64'd0);

        // Red/blue pair packing, pixel 0 arriving with the boundary.
        log_q.delete();
        fr_g = 2;
        tick(1'b1, 12'h800, 12'h000, 12'h000);
        tick(1'b1, 12'h000, 12'h000, 12'hFFF);
        for (int i = 2; i < NPIX; i++) tick(1'b1, 12'(($urandom)), 12'(($urandom)), 12'(($urandom)));
        idle(6);
        chk("pair_cnt", 64'(log_q.size()), 64'd4);
        chk("pair_word", {32'd0, log_q[0][31:0]}, {32'd0, 32'h001F_8000});

        // Overflow with sink stalled, then recovery.
        rdy_g = 1'b0; fr_g = 3;
        for (int i = 0; i < NPIX; i++) tick(1'b1, 12'h123, 12'h456, 12'h789);
        fr_g = 4;
        tick(1'b1, 12'h111, 12'h222, 12'h333);
        tick(1'b1, 12'h444, 12'h555, 12'h666);
        settle();
        chk("ovf_set", {63'd0, ooverflow}, 64'd1);
        chk("ovf_fill", 64'(ofill), 64'd4);
        rdy_g = 1'b1; idle(6);
        log_q.delete();
        fr_g = 5;
        for (int i = 0; i < NPIX; i++) tick(1'b1, 12'(($urandom)), 12'(($urandom)), 12'(($urandom)));
        idle(6);
        chk("recov_cnt", 64'(log_q.size()), 64'd4);
        chk("recov_tags", {60'd0, log_q[0][33:32], log_q[3][33:32]}, {60'd0, 4'b1001});
        chk("ovf_sticky", {63'd0, ooverflow}, 64'd1);

        // Truncated frame followed by a full frame.
        fr_g = 6;
        for (int i = 0; i < 3; i++) tick(1'b1, 12'(($urandom)), 12'(($urandom)), 12'(($urandom)));
        idle(4);
        log_q.delete();
        fr_g = 7;
        for (int i = 0; i < NPIX; i++) begin
            pr[i] = 12'($urandom); pg[i] = 12'($urandom); pb[i] = 12'($urandom);
            tick(1'b1, pr[i], pg[i], pb[i]);
        end
        idle(6);
        chk("trunc_cnt", 64'(log_q.size()), 64'd4);
        chk("trunc_w0", {30'd0, log_q[0]},
            {30'd0, 2'b10, rgb565(pr[1], pg[1], pb[1]), rgb565(pr[0], pg[0], pb[0])});

        // Reset with two words buffered.
        rdy_g = 1'b0; fr_g = 8;
        for (int i = 0; i < 4; i++) tick(1'b1, 12'hABC, 12'hDEF, 12'h012);
        do_reset();
        settle();
        chk("mid_rst_ovalid", {63'd0, ovalid}, 64'd0);
        chk("mid_rst_fill", 64'(ofill), 64'd0);
        rdy_g = 1'b1;
        for (int i = 0; i < NPIX; i++) tick(1'b1, 12'hFFF, 12'hFFF, 12'hFFF);
        settle();
        chk("ignored_fill", 64'(ofill), 64'd0);
        fr_g = 9;
        for (int i = 0; i < NPIX; i++) tick(1'b1, 12'(($urandom)), 12'(($urandom)), 12'(($urandom)));
        idle(6);

`ifdef PACKER_TEST_PATTERN_EN
        log_q.delete();
        fr_g = 10; tst_g = 1'b1;
        for (int i = 0; i < NPIX; i++) tick(1'b1, 12'(($urandom)), 12'(($urandom)), 12'(($urandom)));
        idle(6);
        tst_g = 1'b0;
        chk("tp_w0", {32'd0, log_q[0][31:0]}, {32'd0, 32'h0001_0000});
        chk("tp_w3", {32'd0, log_q[3][31:0]}, {32'd0, 32'h0007_0006});
`endif

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 29) == 0) fr_g = fr_g + 32'($urandom_range(1, 3));
                rdy_g = ($urandom_range(0, 3) != 0);
`ifdef PACKER_TEST_PATTERN_EN
                tst_g = ($urandom_range(0, 1) != 0);
`endif
                tick($urandom_range(0, 9) < 7, 12'($urandom), 12'($urandom), 12'($urandom));
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
